grid_scan_reader: RTL and testbench

Streams the 30x40 one-bit cell grid out of the cell SRAM in raster order: row 0 column 0 first, column-fastest. It issues SRAM read addresses, absorbs the SRAM's one-cycle read latency, and presents each cell on a valid/ready stream with row/column coordinates. A two-entry output buffer allows arbitrary consumer back-pressure without losing cells. It sits between the cell SRAM read port and the display/next-generation logic.

---
 rtl/grid_scan_reader.sv | 125 ++++++++++++
 tb/tb_grid_scan_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scan_reader.sv
// grid_scan_reader: streams the ROWSxCOLS cell grid out of SRAM in raster order as a
// valid/ready beat stream, absorbing the one-cycle read latency with a 2-entry buffer.
module grid_scan_reader #(
    parameter int ROWS       = 30,
    parameter int COLS       = 40,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_cell,
    output logic [4:0]            out_row,
    output logic [5:0]            out_col,
    output logic                  out_last
);
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] cnt_q, addr_q;
    logic [4:0]            row_q;
    logic [5:0]            col_q;
    logic                  rd_q;
    logic [11:0]           tag_q;
    logic [12:0]           head_q, tail_q, in_e;
    logic [1:0]            count_q;
    logic [2:0]            occ;
    logic                  pop, push, issue_last, col_wrap, flush;

    assign pop        = out_valid && out_ready;
    assign push       = rd_q;
    assign out_valid  = count_q != 2'd0;
    assign {out_cell, out_row, out_col, out_last} = head_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign issue_last = cnt_q == ADDR_WIDTH'(CELLS - 1);
    assign col_wrap   = col_q == 6'(COLS - 1);
    // Credit includes the beat leaving this cycle so a full buffer keeps streaming.
    assign occ        = {1'b0, count_q} + {2'b0, rd_q};
    assign mem_rd     = state_q == SCAN && occ < 3'd2 + {2'b0, pop};
    assign mem_addr   = mem_rd ? cnt_q : addr_q;
    assign in_e       = {mem_data, tag_q};
    assign flush      = abort || state_q == IDLE;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort)
            state_d = IDLE;
        else if (state_q == IDLE && start)
            state_d = SCAN;
        else if (state_q == SCAN && mem_rd && issue_last)
            state_d = DRAIN;
        else if (state_q == DRAIN && pop && out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Issue side: linear address plus row/col tags that travel with each read.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            rd_q   <= 1'b0;
            tag_q  <= '0;
        end else if (flush) begin
            cnt_q  <= '0;
            addr_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= mem_rd;
            if (mem_rd) begin
                addr_q <= cnt_q;
                tag_q  <= {row_q, col_q, issue_last};
                cnt_q  <= issue_last ? cnt_q : cnt_q + ADDR_WIDTH'(1);
                col_q  <= col_wrap ? 6'd0 : col_q + 6'd1;
                row_q  <= col_wrap ? row_q + 5'd1 : row_q;
            end
        end
    end

    // Two-entry FIFO with head_q always presented on the output.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
                head_q <= in_e;
            else if (pop && count_q == 2'd2)
                head_q <= tail_q;
            if (push && (count_q == 2'd2 || (count_q == 2'd1 && !pop)))
                tail_q <= in_e;
        end
    end
endmodule

// File: tb/tb_grid_scan_reader.sv
// tb_grid_scan_reader: table-driven scans of grid_scan_reader against an SRAM model,
// with a beat scoreboard filled at start and drained as beats are accepted.
module tb_grid_scan_reader;
    localparam int ROWS = 30, COLS = 40, AW = 11, CELLS = ROWS * COLS;

    logic clk_74a = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic mem_data = 1'b0, out_ready = 1'b0;
    logic busy, done, mem_rd, out_valid, out_cell, out_last;
    logic [AW-1:0] mem_addr;
    logic [4:0] out_row;
    logic [5:0] out_col;
    logic [12:0] f;

    typedef struct {
        int pat;
        int pct;
        int stall;
        int abort_at;
        int beats;
        int done_rel;
    } vec_t;

    vec_t vecs[5];
    logic mem [0:2047];
    logic nxt;
    logic [12:0] exp_q[$];
    logic [12:0] prev_f, b39, b40, e;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, e0 = 0, pct = 0, rel = 0;
    int beats = 0, issued = 0, accepted = 0, exp_addr = 0;
    logic mon_on = 1'b0, prev_stall = 1'b0;

    assign f = {out_cell, out_row, out_col, out_last};

    grid_scan_reader #(.ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)) dut (
        .clk_74a(clk_74a), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_cell(out_cell), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    initial forever #5 clk_74a = ~clk_74a;
    initial forever begin @(posedge clk_74a); cyc++; end

    initial forever begin
        @(posedge clk_74a);
        #2;
        out_ready = pct >= 100 ? 1'b1 : pct <= 0 ? 1'b0 : (int'($urandom_range(99)) < pct);
    end

    // SRAM: data for the address seen this cycle appears in the next cycle.
    initial forever begin
        @(negedge clk_74a);
        nxt = mem[mem_addr];
        @(posedge clk_74a);
        #1;
        mem_data = nxt;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic prep(input int pat);
        exp_q.delete();
        for (int a = 0; a < CELLS; a++) begin
            mem[a] = pat == 0 ? 1'((a / COLS + a % COLS) % 2) : 1'($urandom_range(1));
            exp_q.push_back({mem[a], 5'(a / COLS), 6'(a % COLS), a == CELLS - 1});
        end
        beats = 0;
        issued = 0;
        accepted = 0;
        exp_addr = 0;
        mon_on = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(output int r);
        int n;
        n = 0;
        while (!done && n < 20000) begin tick(); n++; end
        check("done_seen", done, 1);
        check("done_busy0", busy, 0);
        r = cyc - e0 + 1;
    endtask

    task automatic chk_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_cell", out_cell, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int r;
        prep(v.pat);
        pct = v.stall > 0 ? 0 : v.pct;
        pulse_start();
        check("start_busy", busy, 1);
        check("start_rd", mem_rd, 1);
        check("start_addr", mem_addr, 0);
        tick();
        check("valid_e2", out_valid, 0);
        tick();
        check("valid_e3", out_valid, 1);
        if (v.stall > 0) begin
            repeat (v.stall - 2) tick();
            check("stall_rd", mem_rd, 0);
            check("stall_addr", mem_addr, 1);
            check("stall_issued", issued, 2);
            check("stall_head", f, {mem[0], 5'd0, 6'd0, 1'b0});
            pct = v.pct;
        end
        if (v.abort_at >= 0) begin
            repeat (v.abort_at - 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_beats", beats, v.beats);
            repeat (3) begin check("abort_nodone", done, 0); tick(); end
            check("abort_quiet", beats, v.beats);
        end else begin
            wait_done(r);
            if (v.done_rel > 0) check("done_rel", r, v.done_rel);
            tick();
            check("done_pulse", done, 0);
            check("beats", beats, v.beats);
            check("q_empty", exp_q.size(), 0);
            check("wrap_b39", b39, {mem[39], 5'd0, 6'd39, 1'b0});
            check("wrap_b40", b40, {mem[40], 5'd1, 6'd0, 1'b0});
        end
    endtask

    always @(negedge clk_74a) begin
        if (mon_on && reset_n) begin
            if (mem_rd) begin
                check("mem_addr", mem_addr, exp_addr);
                exp_addr++;
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", f, prev_f);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got %0h expected no beat at cycle %0d", f, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", f, e);
                end
                if (beats == 39) b39 = f;
                if (beats == 40) b40 = f;
                beats++;
                accepted++;
            end
            check("outstanding", (issued - accepted) <= 2, 1);
            if (done) check("done_and_busy", busy, 0);
            prev_stall = out_valid && !out_ready;
            prev_f = f;
        end else
            prev_stall = 1'b0;
    end

    initial begin
        vecs[0] = '{0, 100, 0, -1, CELLS, 1203};
        vecs[1] = '{1, 50, 0, -1, CELLS, -1};
        vecs[2] = '{0, 100, 10, -1, CELLS, 1211};
        vecs[3] = '{0, 100, 0, 500, 500, -1};
        vecs[4] = '{1, 30, 0, -1, CELLS, -1};
        for (int a = 0; a < 2048; a++) mem[a] = 1'b0;
        repeat (3) @(posedge clk_74a);
        #1;
        chk_reset();
        reset_n = 1'b1;
        tick();
        foreach (vecs[i]) run_vec(vecs[i]);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);

        // start mid-scan is ignored; start on the done cycle launches the next scan
        prep(0);
        pct = 100;
        pulse_start();
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(rel);
        check("chain1_rel", rel, 1203);
        check("chain1_beats", beats, CELLS);
        check("chain1_q", exp_q.size(), 0);
        prep(1);
        pulse_start();
        check("chain2_busy", busy, 1);
        check("chain2_done", done, 0);
        check("chain2_rd", mem_rd, 1);
        check("chain2_addr", mem_addr, 0);
        wait_done(rel);
        check("chain2_rel", rel, 1203);
        check("chain2_beats", beats, CELLS);
        check("chain2_q", exp_q.size(), 0);
        tick();

        prep(0);
        pct = 100;
        pulse_start();
        repeat (300) tick();
        #2;
        mon_on = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_idle", busy, 0);

        prep(0);
        pct = 0;
        pulse_start();
        repeat (5) tick();
        check("prestall_rd", mem_rd, 0);
        check("prestall_valid", out_valid, 1);
        #2;
        mon_on = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset();
        tick();
        reset_n = 1'b1;
        tick();
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
